// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V control sequencer: fetch/decode/execute/memory/writeback FSM for a shared memory port.
// Optional retired-instruction counter enabled by defining MC_RETIRE_CNT_EN.
module multicycle_control #(
  parameter bit ILLEGAL_HALT = 1'b1,
  parameter int RETIRE_W     = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] OPCode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       PCSource,
  output logic       Branch,
  output logic       Trap,
  output logic [3:0] State
`ifdef MC_RETIRE_CNT_EN
  ,
  output logic [RETIRE_W-1:0] Retired
`endif
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_ALU = 4'd8,
    S_WB_MEM = 4'd9,
    S_BRANCH = 4'd10,
    S_HALT   = 4'd11
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_source;
    logic       branch;
    logic       halt;
  } ctrl_t;

  state_t state_reg, state_next;
  ctrl_t  ctrl_reg;
  logic   op_known;
  logic   fetch_done;

  // Moore outputs for a state; registered from state_next so they line up with state_reg.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE: c.alu_src_b = 2'b10;
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = 2'b11;
      end
      S_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_WB_ALU: c.reg_write = 1'b1;
      S_WB_MEM: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.branch    = 1'b1;
        c.pc_source = 1'b1;
      end
      S_HALT:  c.halt = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  assign op_known = (OPCode == OP_R) || (OPCode == OP_I) || (OPCode == OP_LOAD) ||
                    (OPCode == OP_STORE) || (OPCode == OP_BRANCH);

  always_comb begin
    state_next = S_IDLE;
    case (state_reg)
      S_IDLE:   state_next = S_FETCH;
      S_FETCH:  state_next = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (OPCode)
          OP_R:               state_next = S_EXEC_R;
          OP_I:               state_next = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_next = S_ADDR;
          OP_BRANCH:          state_next = S_BRANCH;
          default:            state_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_EXEC_R: state_next = S_WB_ALU;
      S_EXEC_I: state_next = S_WB_ALU;
      S_ADDR:   state_next = (OPCode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: state_next = MemReady ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR: state_next = MemReady ? S_FETCH : S_MEM_WR;
      S_WB_ALU: state_next = S_FETCH;
      S_WB_MEM: state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      ctrl_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= decode_ctrl(state_next);
    end
  end

  // The two Mealy terms: IR/PC load on fetch completion, PC load on a taken branch.
  assign fetch_done = (state_reg == S_FETCH) && MemReady;
  assign IRWrite    = fetch_done;
  assign PCWrite    = fetch_done || (ctrl_reg.branch && Zero);

  assign IorD     = ctrl_reg.iord;
  assign MemRead  = ctrl_reg.mem_read;
  assign MemWrite = ctrl_reg.mem_write;
  assign MemToReg = ctrl_reg.mem_to_reg;
  assign RegWrite = ctrl_reg.reg_write;
  assign ALUSrcA  = ctrl_reg.alu_src_a;
  assign ALUSrcB  = ctrl_reg.alu_src_b;
  assign ALUOp    = ctrl_reg.alu_op;
  assign PCSource = ctrl_reg.pc_source;
  assign Branch   = ctrl_reg.branch;
  assign Trap     = ctrl_reg.halt ||
                    ((state_reg == S_DECODE) && !op_known && (ILLEGAL_HALT == 1'b0));
  assign State    = state_reg;

`ifdef MC_RETIRE_CNT_EN
  logic [RETIRE_W-1:0] retired_reg;
  logic                retire_evt;

  assign retire_evt = (state_reg == S_WB_ALU) || (state_reg == S_WB_MEM) ||
                      (state_reg == S_BRANCH) || ((state_reg == S_MEM_WR) && MemReady);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retired_reg <= '0;
    end else if (retire_evt) begin
      retired_reg <= retired_reg + {{(RETIRE_W-1){1'b0}}, 1'b1};
    end
  end

  assign Retired = retired_reg;
`else
  logic [RETIRE_W-1:0] unused_retire_w;
  assign unused_retire_w = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control; a second instance runs with ILLEGAL_HALT=0.
module tb_multicycle_control;

  logic       clk;
  logic       reset_n;
  logic [6:0] OPCode;
  logic       Zero;
  logic       MemReady;

  logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, MemToReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp;
  logic       PCSource, Branch, Trap;
  logic [3:0] State;

  logic       PCWrite0, IRWrite0, IorD0, MemRead0, MemWrite0, MemToReg0, RegWrite0, ALUSrcA0;
  logic [1:0] ALUSrcB0, ALUOp0;
  logic       PCSource0, Branch0, Trap0;
  logic [3:0] State0;

`ifdef MC_RETIRE_CNT_EN
  logic [31:0] Retired, Retired0;
`endif

  multicycle_control #(.ILLEGAL_HALT(1'b1), .RETIRE_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .OPCode(OPCode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .Branch(Branch),
    .Trap(Trap), .State(State)
`ifdef MC_RETIRE_CNT_EN
    , .Retired(Retired)
`endif
  );

  multicycle_control #(.ILLEGAL_HALT(1'b0), .RETIRE_W(32)) dut0 (
    .clk(clk), .reset_n(reset_n), .OPCode(OPCode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite0), .IRWrite(IRWrite0), .IorD(IorD0), .MemRead(MemRead0),
    .MemWrite(MemWrite0), .MemToReg(MemToReg0), .RegWrite(RegWrite0), .ALUSrcA(ALUSrcA0),
    .ALUSrcB(ALUSrcB0), .ALUOp(ALUOp0), .PCSource(PCSource0), .Branch(Branch0),
    .Trap(Trap0), .State(State0)
`ifdef MC_RETIRE_CNT_EN
    , .Retired(Retired0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [14:0] obs;
  assign obs = {PCWrite, IRWrite, IorD, MemRead, MemWrite, MemToReg, RegWrite, ALUSrcA,
                ALUSrcB, ALUOp, PCSource, Branch, Trap};

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        zero;
    logic        mr;
    logic [3:0]  st;
    logic [14:0] o;
    logic [3:0]  st0;
    logic        tr0;
    int          ret;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [14:0] pk(input logic pcw, irw, iord, mr, mw, m2r, rw, asa,
                                     input logic [1:0] asb, aop,
                                     input logic pcs, br, tr);
    return {pcw, irw, iord, mr, mw, m2r, rw, asa, asb, aop, pcs, br, tr};
  endfunction

  task automatic add(input logic rst, input logic [6:0] op, input logic zero, input logic mr,
                     input logic [3:0] st, input logic [14:0] o,
                     input logic [3:0] st0, input logic tr0, input int ret);
    vec_t v;
    v.rst = rst; v.op = op; v.zero = zero; v.mr = mr; v.st = st; v.o = o;
    v.st0 = st0; v.tr0 = tr0; v.ret = ret;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
    end else begin
      $display("ok   row %0d %s = %h", row, name, act);
    end
  endtask

  localparam logic [6:0] R = 7'b0110011;
  localparam logic [6:0] L = 7'b0000011;
  localparam logic [6:0] S = 7'b0100011;
  localparam logic [6:0] B = 7'b1100011;
  localparam logic [6:0] X = 7'b1111111;

  logic [14:0] F0, F1, DEC, EXR, ADR, MRD, MWR, WBA, WBM, BRZ1, BRZ0, HLT;

  initial begin
    //        pcw irw iod mr mw m2r rw asa asb    aop    pcs br tr
    F0   = pk(0,  0,  0,  1, 0, 0,  0, 0,  2'b01, 2'b00, 0,  0, 0);
    F1   = pk(1,  1,  0,  1, 0, 0,  0, 0,  2'b01, 2'b00, 0,  0, 0);
    DEC  = pk(0,  0,  0,  0, 0, 0,  0, 0,  2'b10, 2'b00, 0,  0, 0);
    EXR  = pk(0,  0,  0,  0, 0, 0,  0, 1,  2'b00, 2'b10, 0,  0, 0);
    ADR  = pk(0,  0,  0,  0, 0, 0,  0, 1,  2'b10, 2'b00, 0,  0, 0);
    MRD  = pk(0,  0,  1,  1, 0, 0,  0, 0,  2'b00, 2'b00, 0,  0, 0);
    MWR  = pk(0,  0,  1,  0, 1, 0,  0, 0,  2'b00, 2'b00, 0,  0, 0);
    WBA  = pk(0,  0,  0,  0, 0, 0,  1, 0,  2'b00, 2'b00, 0,  0, 0);
    WBM  = pk(0,  0,  0,  0, 0, 1,  1, 0,  2'b00, 2'b00, 0,  0, 0);
    BRZ1 = pk(1,  0,  0,  0, 0, 0,  0, 1,  2'b00, 2'b01, 1,  1, 0);
    BRZ0 = pk(0,  0,  0,  0, 0, 0,  0, 1,  2'b00, 2'b01, 1,  1, 0);
    HLT  = pk(0,  0,  0,  0, 0, 0,  0, 0,  2'b00, 2'b00, 0,  0, 1);

    //  rst op z mr  st  outputs  st0 tr0 ret
    add(0, R, 0, 1,  0, 15'd0,    0,  0,  0);   // reset held
    add(1, R, 0, 1,  0, 15'd0,    0,  0,  0);   // released, still IDLE
    add(1, R, 0, 1,  1, F1,       1,  0,  0);   // R-type
    add(1, R, 0, 1,  2, DEC,      2,  0,  0);
    add(1, R, 0, 1,  3, EXR,      3,  0,  0);
    add(1, R, 0, 1,  8, WBA,      8,  0,  0);
    add(1, L, 0, 1,  1, F1,       1,  0,  1);   // load
    add(1, L, 0, 1,  2, DEC,      2,  0,  1);
    add(1, L, 0, 1,  5, ADR,      5,  0,  1);
    add(1, L, 0, 1,  6, MRD,      6,  0,  1);
    add(1, L, 0, 1,  9, WBM,      9,  0,  1);
    add(1, S, 0, 1,  1, F1,       1,  0,  2);   // store with 3 stall cycles
    add(1, S, 0, 1,  2, DEC,      2,  0,  2);
    add(1, S, 0, 1,  5, ADR,      5,  0,  2);
    add(1, S, 0, 0,  7, MWR,      7,  0,  2);
    add(1, S, 0, 0,  7, MWR,      7,  0,  2);
    add(1, S, 0, 0,  7, MWR,      7,  0,  2);
    add(1, S, 0, 1,  7, MWR,      7,  0,  2);
    add(1, B, 1, 0,  1, F0,       1,  0,  3);   // fetch stall, then taken branch
    add(1, B, 1, 0,  1, F0,       1,  0,  3);
    add(1, B, 1, 1,  1, F1,       1,  0,  3);
    add(1, B, 1, 1,  2, DEC,      2,  0,  3);
    add(1, B, 1, 1, 10, BRZ1,    10,  0,  3);
    add(1, B, 0, 1,  1, F1,       1,  0,  4);   // not-taken branch
    add(1, B, 0, 1,  2, DEC,      2,  0,  4);
    add(1, B, 0, 1, 10, BRZ0,    10,  0,  4);
    add(1, X, 0, 1,  1, F1,       1,  0,  5);   // illegal opcode
    add(1, X, 0, 1,  2, DEC,      2,  1,  5);
    add(1, X, 0, 1, 11, HLT,      1,  0,  5);
    add(1, X, 0, 1, 11, HLT,      2,  1,  5);
    add(1, X, 0, 1, 11, HLT,      1,  0,  5);
    add(0, R, 0, 1,  0, 15'd0,    0,  0,  0);   // reset out of HALT
    add(1, R, 0, 1,  0, 15'd0,    0,  0,  0);
    add(1, R, 0, 1,  1, F1,       1,  0,  0);
  end

  initial begin
    reset_n  = 1'b0;
    OPCode   = R;
    Zero     = 1'b0;
    MemReady = 1'b1;
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      reset_n  = tbl[i].rst;
      OPCode   = tbl[i].op;
      Zero     = tbl[i].zero;
      MemReady = tbl[i].mr;
      @(negedge clk);
      chk("state", i, {28'd0, State}, {28'd0, tbl[i].st});
      chk("outputs", i, {17'd0, obs}, {17'd0, tbl[i].o});
      chk("state_nohalt", i, {28'd0, State0}, {28'd0, tbl[i].st0});
      chk("trap_nohalt", i, {31'd0, Trap0}, {31'd0, tbl[i].tr0});
`ifdef MC_RETIRE_CNT_EN
      chk("retired", i, Retired, tbl[i].ret);
`endif
    end

    // Reset asserted in the middle of a stalled store: write must drop immediately.
    @(posedge clk); #1; OPCode = S; MemReady = 1'b1;   // DECODE
    @(posedge clk); #1;                                // ADDR
    @(posedge clk); #1; MemReady = 1'b0;               // MEM_WR
    @(negedge clk);
    chk("midrst_pre_state", 100, {28'd0, State}, 32'd7);
    chk("midrst_pre_memwrite", 100, {31'd0, MemWrite}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_state", 101, {28'd0, State}, 32'd0);
    chk("midrst_outputs", 101, {17'd0, obs}, 32'd0);
    @(posedge clk); #1;
    reset_n  = 1'b1;
    MemReady = 1'b1;
    @(negedge clk);
    chk("midrst_idle", 102, {28'd0, State}, 32'd0);
    @(negedge clk);
    chk("midrst_fetch", 103, {28'd0, State}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle RISC-V control sequencer that replaces the single-cycle control unit when the core runs on one shared memory port. A registered Moore FSM, with two Mealy terms, steps each instruction through fetch, decode, execute, memory and writeback. It drives the datapath muxes, register and memory enables, and ALUOp towards the ALU control. It stalls on a memory ready handshake.

Parameters:
ILLEGAL_HALT, 1, 1: an unknown opcode parks the FSM in HALT until reset; 0: Trap pulses one cycle and the FSM returns to FETCH.
RETIRE_W, 32, width of the retired-instruction counter (used only with the optional feature).

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
OPCode  input  7  instruction[6:0] from IR, sampled in DECODE
Zero  input  1  ALU zero flag
MemReady  input  1  memory completed current access this cycle
PCWrite  output  1  PC load enable
IRWrite  output  1  instruction register load enable
IorD  output  1  memory address select: 0=PC, 1=ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
MemToReg  output  1  writeback select: 0=ALUOut, 1=MDR
RegWrite  output  1  register file write enable
ALUSrcA  output  1  0=PC, 1=rs1
ALUSrcB  output  2  00=rs2, 01=constant 4, 10=immediate
ALUOp  output  2  00=add, 01=sub/compare, 10=R-type funct, 11=I-type funct
PCSource  output  1  0=ALU result, 1=ALUOut (branch target)
Branch  output  1  high in BRANCH state
Trap  output  1  illegal-opcode indication
State  output  4  current state, for debug

Behaviour:
- Async reset (reset_n=0) forces State=IDLE. All outputs are 0 while in IDLE.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, ADDR=5, MEM_RD=6, MEM_WR=7, WB_ALU=8, WB_MEM=9, BRANCH=10, HALT=11. Codes 12-15 go to IDLE on the next edge.
- IDLE: all outputs 0 -> FETCH unconditionally.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=0.
  - IRWrite and PCWrite equal MemReady (Mealy).
  - Stay in FETCH while MemReady=0; go to DECODE when MemReady=1.
- DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=00 (precompute branch target). Next state by OPCode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> ADDR
  - 1100011 -> BRANCH
  - any other -> HALT if ILLEGAL_HALT=1, else FETCH with Trap=1 for that DECODE cycle.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> WB_ALU.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=11 -> WB_ALU.
- ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. OPCode 0000011 -> MEM_RD; otherwise -> MEM_WR.
- MEM_RD: MemRead=1, IorD=1. Hold until MemReady=1 -> WB_MEM.
- MEM_WR: MemWrite=1, IorD=1. Hold until MemReady=1 -> FETCH.
- WB_ALU: RegWrite=1, MemToReg=0 -> FETCH.
- WB_MEM: RegWrite=1, MemToReg=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch=1, PCSource=1. PCWrite equals Zero (Mealy). -> FETCH.
- HALT: Trap=1 held; all enables 0; exit only via reset.
- Any output not listed for a state is 0. MemRead and MemWrite are never high together.
- Latency with MemReady tied to 1: R/I=4 cycles, load=5, store=4, branch=3. Each MemReady=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- Reset mid-access: outputs drop combinationally to 0 (no partial write continues); restart at IDLE.

Optional Feature:
MC_RETIRE_CNT_EN
- Defined:
  - Adds output Retired[RETIRE_W-1:0], reset to 0.
  - Increments by 1 on each clock edge leaving WB_ALU, WB_MEM, BRANCH, or MEM_WR with MemReady=1.
  - Wraps from all-ones to 0.
  - Illegal opcodes are not counted.
- Undefined: port and counter absent; FSM behaviour identical.

Test Plan:
- Reset release, MemReady=1, OPCode=0110011 -> State sequence 0,1,2,3,8,1. RegWrite=1 only in state 8. ALUOp=10 in state 3.
- OPCode=0000011, MemReady=1 -> states 1,2,5,6,9,1. MemToReg=1 and RegWrite=1 in state 9. IorD=1 in state 6.
- OPCode=0100011 with MemReady=0 for 3 cycles in MEM_WR -> MemWrite=1 held 4 cycles, then FETCH. RegWrite stays 0 throughout.
- OPCode=1100011 -> in BRANCH: Zero=1 gives PCWrite=1 and PCSource=1; repeat with Zero=0 gives PCWrite=0. Both return to FETCH after 3 cycles.
- FETCH with MemReady=0 for 2 cycles -> IRWrite=0 and PCWrite=0 in those cycles; both pulse 1 in the MemReady=1 cycle.
- OPCode=1111111, ILLEGAL_HALT=1 -> State=11 with Trap=1 held; reset_n=0 pulse returns to IDLE with Trap=0. With MC_RETIRE_CNT_EN defined, Retired stays unchanged.
